axi_stream_to_uart_tx: RTL



---
 rtl/axi_stream_to_uart_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/axi_stream_to_uart_tx.sv
// AXI-Stream to UART transmitter: each accepted beat is sent as NUM_WORDS back-to-back frames,
// LSB word first and LSB bit first, on a registered tx line that idles high.
module axi_stream_to_uart_tx #(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned W_IN             = 16,
  parameter int unsigned NUM_STOP         = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W_IN-1:0] s_data,
  output logic            tx,
  output logic            busy
);

  localparam int unsigned NUM_WORDS   = W_IN / BITS_PER_WORD;
  localparam int unsigned STOP_CLOCKS = NUM_STOP * CLOCKS_PER_PULSE;
  localparam int unsigned W_CLK  = (STOP_CLOCKS > 1) ? $clog2(STOP_CLOCKS) : 1;
  localparam int unsigned W_BIT  = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int unsigned W_WORD = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  if ((W_IN % BITS_PER_WORD) != 0) begin : g_bad_width
    $error("W_IN must be an integer multiple of BITS_PER_WORD");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

  state_t              r_state, w_state_d;
  logic [W_CLK-1:0]    r_c_clocks, w_c_clocks_d;
  logic [W_BIT-1:0]    r_c_bits, w_c_bits_d;
  logic [W_WORD-1:0]   r_c_words, w_c_words_d;
  logic [W_IN-1:0]     r_shift, w_shift_d, w_shift_next;
  logic                r_tx, w_tx_d;
  logic                r_s_ready, w_s_ready_d;
  logic                r_busy, w_busy_d;

  assign w_shift_next = r_shift >> 1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_c_clocks <= '0;
      r_c_bits   <= '0;
      r_c_words  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_s_ready  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_c_clocks <= w_c_clocks_d;
      r_c_bits   <= w_c_bits_d;
      r_c_words  <= w_c_words_d;
      r_shift    <= w_shift_d;
      r_tx       <= w_tx_d;
      r_s_ready  <= w_s_ready_d;
      r_busy     <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_c_clocks_d = r_c_clocks;
    w_c_bits_d   = r_c_bits;
    w_c_words_d  = r_c_words;
    w_shift_d    = r_shift;
    w_tx_d       = r_tx;
    w_s_ready_d  = r_s_ready;
    w_busy_d     = r_busy;
    case (r_state)
      StIdle: begin
        // Ready rises one edge after reset release and stays up until the handshake
        w_tx_d      = 1'b1;
        w_s_ready_d = 1'b1;
        if (s_valid && r_s_ready) begin
          w_shift_d    = s_data;
          w_s_ready_d  = 1'b0;
          w_busy_d     = 1'b1;
          w_tx_d       = 1'b0;
          w_c_clocks_d = '0;
          w_state_d    = StStart;
        end
      end
      StStart: begin
        if (r_c_clocks == W_CLK'(CLOCKS_PER_PULSE - 1)) begin
          w_c_clocks_d = '0;
          w_tx_d       = r_shift[0];
          w_state_d    = StData;
        end else begin
          w_c_clocks_d = r_c_clocks + W_CLK'(1);
        end
      end
      StData: begin
        if (r_c_clocks == W_CLK'(CLOCKS_PER_PULSE - 1)) begin
          w_c_clocks_d = '0;
          w_shift_d    = w_shift_next;
          if (r_c_bits == W_BIT'(BITS_PER_WORD - 1)) begin
            w_c_bits_d = '0;
            w_tx_d     = 1'b1;
            w_state_d  = StStop;
          end else begin
            w_c_bits_d = r_c_bits + W_BIT'(1);
            w_tx_d     = w_shift_next[0];
          end
        end else begin
          w_c_clocks_d = r_c_clocks + W_CLK'(1);
        end
      end
      StStop: begin
        if (r_c_clocks == W_CLK'(STOP_CLOCKS - 1)) begin
          w_c_clocks_d = '0;
          // Next word starts on this edge with no idle gap
          if (r_c_words < W_WORD'(NUM_WORDS - 1)) begin
            w_c_words_d = r_c_words + W_WORD'(1);
            w_tx_d      = 1'b0;
            w_state_d   = StStart;
          end else begin
            w_c_words_d = '0;
            w_tx_d      = 1'b1;
            w_s_ready_d = 1'b1;
            w_busy_d    = 1'b0;
            w_state_d   = StIdle;
          end
        end else begin
          w_c_clocks_d = r_c_clocks + W_CLK'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign tx      = r_tx;
  assign s_ready = r_s_ready;
  assign busy    = r_busy;

endmodule
